// File: rtl/cardinal_mem_pkg.sv
// cardinal_mem_pkg: shared widths and encodings for the data-memory arbiter
package cardinal_mem_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 64;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        O_NONE,
        O_CPU_RD,
        O_HOST_RD
    } owner_e;

    typedef enum logic [1:0] {
        G_NONE,
        G_CPU,
        G_HOST
    } grant_e;
endpackage

// File: rtl/mem_starve_ctr.sv
// mem_starve_ctr: saturating count of host cycles lost to the CPU
module mem_starve_ctr
    import cardinal_mem_pkg::*;
#(
    parameter int MAX = 4,
    parameter int W   = CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Clear has priority; increment stops at MAX
    always_comb begin
        cnt_d = clr_i ? '0 : (inc_i && cnt_q != W'(MAX)) ? cnt_q + 1'b1 : cnt_q;
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign at_max_o = cnt_q == W'(MAX);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one synchronous data memory between the CPU EX port and a host port
module data_mem_arbiter
    import cardinal_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_memEn,
    input  logic              cpu_memWrEn,
    input  logic [ADDR_W-1:0] cpu_memAddr,
    input  logic [DATA_W-1:0] cpu_dataOut,
    output logic [DATA_W-1:0] cpu_dataIn,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic              mem_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    grant_e            grant;
    owner_e            owner_q, owner_d;
    logic              host_at_max;
    logic              force_host;
    logic [DATA_W-1:0] host_rdata_q;

    mem_starve_ctr #(
        .MAX(STARVE_MAX),
        .W  (CNT_W)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (grant == G_CPU && host_req),
        .clr_i   (grant == G_HOST || !host_req),
        .at_max_o(host_at_max)
    );

    // Grant decision (forced host, then CPU, then host) and the owner of the access being issued
    always_comb begin
        force_host = host_req && host_at_max;
        grant      = reset ? G_NONE : force_host ? G_HOST : cpu_memEn ? G_CPU : host_req ? G_HOST : G_NONE;
        owner_d    = (grant == G_HOST && !host_wr) ? O_HOST_RD :
                     (grant == G_CPU && !cpu_memWrEn) ? O_CPU_RD : O_NONE;
    end

    // Owner of last cycle's access and the host read-return register; reset drops any pending return
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q      <= O_NONE;
            host_rdata_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (host_rvalid)
                host_rdata_q <= mem_rdata;
        end
    end

    assign cpu_stall   = !reset && force_host && cpu_memEn;
    assign host_gnt    = grant == G_HOST;
    assign mem_en      = grant != G_NONE;
    assign mem_wr_en   = grant == G_HOST ? host_wr : grant == G_CPU ? cpu_memWrEn : 1'b0;
    assign mem_addr    = grant == G_HOST ? host_addr : grant == G_CPU ? cpu_memAddr : '0;
    assign mem_wdata   = grant == G_HOST ? host_wdata : grant == G_CPU ? cpu_dataOut : '0;
    assign host_rvalid = !reset && owner_q == O_HOST_RD;
    assign host_rdata  = host_rdata_q;
    assign cpu_dataIn  = mem_rdata;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed stimulus checked each cycle against a behavioural arbiter model
module tb_data_mem_arbiter;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_memEn, cpu_memWrEn, host_req, host_wr;
    logic [31:0] cpu_memAddr, host_addr;
    logic [63:0] cpu_dataOut, host_wdata;
    logic [63:0] cpu_dataIn, host_rdata, mem_wdata;
    logic        cpu_stall, host_gnt, host_rvalid, mem_en, mem_wr_en;
    logic [31:0] mem_addr;
    logic [63:0] mem_rdata = '0;

    int errors = 0;
    int checks = 0;

    data_mem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_memEn  (cpu_memEn),
        .cpu_memWrEn(cpu_memWrEn),
        .cpu_memAddr(cpu_memAddr),
        .cpu_dataOut(cpu_dataOut),
        .cpu_dataIn (cpu_dataIn),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .mem_en     (mem_en),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] init_val(int a);
        return a == 'h10 ? 64'hDEAD : a == 'h20 ? 64'hC0FFEE : a == 'h30 ? 64'h5555 : 64'(a) * 64'h0101;
    endfunction

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chk1(string n, logic a, logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", n, a, e);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Environment memory: one-cycle synchronous read
    logic [63:0] env_mem [256];
    logic        env_init = 1'b0;
    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
            env_init <= 1'b1;
        end else if (mem_en) begin
            if (mem_wr_en)
                env_mem[mem_addr[7:0]] <= mem_wdata;
            else
                mem_rdata <= env_mem[mem_addr[7:0]];
        end
    end

    // Behavioural model: reference memory, denied-host streak, and pending read returns
    logic [63:0] ref_mem [256];
    logic        ref_init = 1'b0;
    int          denied = 0;
    logic        hrd_pend = 1'b0, crd_pend = 1'b0;
    logic [63:0] hrd_val, crd_val;
    logic [63:0] exp_hrdata = '0;
    logic        m_force, m_gh, m_gc;
    always @(negedge clk) begin
        if (!ref_init) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            ref_init = 1'b1;
        end
        chk("host_rdata", host_rdata, exp_hrdata);
        if (reset) begin
            chk1("rst_rvalid", host_rvalid, 1'b0);
            chk1("rst_gnt", host_gnt, 1'b0);
            chk1("rst_stall", cpu_stall, 1'b0);
            chk1("rst_mem_en", mem_en, 1'b0);
            chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
            chk("rst_mem_addr", 64'(mem_addr), 64'h0);
            chk("rst_mem_wdata", mem_wdata, 64'h0);
            exp_hrdata = '0;
            denied = 0;
            hrd_pend = 1'b0;
            crd_pend = 1'b0;
        end else begin
            chk1("host_rvalid", host_rvalid, hrd_pend);
            if (hrd_pend) exp_hrdata = hrd_val;
            if (crd_pend) chk("cpu_dataIn", cpu_dataIn, crd_val);
            m_force = host_req && denied == SMAX;
            m_gh = m_force || (host_req && !cpu_memEn);
            m_gc = cpu_memEn && !m_force;
            chk1("host_gnt", host_gnt, m_gh);
            chk1("cpu_stall", cpu_stall, cpu_memEn && m_force);
            chk1("mem_en", mem_en, m_gh || m_gc);
            chk1("mem_wr_en", mem_wr_en, m_gh ? host_wr : m_gc ? cpu_memWrEn : 1'b0);
            if (m_gh || m_gc) chk("mem_addr", 64'(mem_addr), 64'(m_gh ? host_addr : cpu_memAddr));
            if (m_gh && host_wr) chk("mem_wdata", mem_wdata, host_wdata);
            if (m_gc && cpu_memWrEn) chk("mem_wdata", mem_wdata, cpu_dataOut);
            denied = (host_req && !m_gh) ? denied + 1 : 0;
            hrd_pend = m_gh && !host_wr;
            hrd_val = ref_mem[host_addr[7:0]];
            crd_pend = m_gc && !cpu_memWrEn;
            crd_val = ref_mem[cpu_memAddr[7:0]];
            if (m_gh && host_wr) ref_mem[host_addr[7:0]] = host_wdata;
            if (m_gc && cpu_memWrEn) ref_mem[cpu_memAddr[7:0]] = cpu_dataOut;
        end
    end

    // Directed stimulus with hand-computed literal expectations
    initial begin
        reset = 1'b1;
        cpu_memEn = 1'b0;
        cpu_memWrEn = 1'b0;
        cpu_memAddr = '0;
        cpu_dataOut = '0;
        host_req = 1'b0;
        host_wr = 1'b0;
        host_addr = '0;
        host_wdata = '0;
        tick;
        @(negedge clk);
        chk1("t0_mem_en", mem_en, 1'b0);
        tick;
        reset = 1'b0;
        // host-only read of 0x10
        host_req = 1'b1;
        host_addr = 32'h10;
        @(negedge clk);
        chk1("t1_gnt", host_gnt, 1'b1);
        tick;
        host_req = 1'b0;
        @(negedge clk);
        chk1("t1_rvalid", host_rvalid, 1'b1);
        tick;
        @(negedge clk);
        chk("t1_rdata", host_rdata, 64'hDEAD);
        chk1("t1_rvalid_pulse", host_rvalid, 1'b0);
        // CPU-only reads of 0x20
        cpu_memEn = 1'b1;
        cpu_memAddr = 32'h20;
        for (int i = 0; i < 6; i++) begin
            tick;
            @(negedge clk);
            chk1("t2_stall", cpu_stall, 1'b0);
            if (i > 0) chk("t2_data", cpu_dataIn, 64'hC0FFEE);
        end
        // CPU write then read-back
        tick;
        cpu_memWrEn = 1'b1;
        cpu_memAddr = 32'h40;
        cpu_dataOut = 64'hABC;
        tick;
        cpu_memWrEn = 1'b0;
        tick;
        @(negedge clk);
        chk("t2_wr_rd", cpu_dataIn, 64'hABC);
        // contention: force every fifth cycle
        tick;
        cpu_memAddr = 32'h21;
        host_req = 1'b1;
        host_addr = 32'h11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("t3_stall", cpu_stall, i % 5 == 4);
            chk1("t3_gnt", host_gnt, i % 5 == 4);
            tick;
        end
        host_req = 1'b0;
        cpu_memEn = 1'b0;
        tick;
        // forced host write, then CPU reads it back
        cpu_memEn = 1'b1;
        cpu_memAddr = 32'h30;
        host_req = 1'b1;
        host_wr = 1'b1;
        host_addr = 32'h30;
        host_wdata = 64'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("t4_stall", cpu_stall, i == 4);
            tick;
        end
        host_req = 1'b0;
        host_wr = 1'b0;
        @(negedge clk);
        chk1("t4_regrant", cpu_stall, 1'b0);
        tick;
        @(negedge clk);
        chk("t4_data", cpu_dataIn, 64'h1234);
        cpu_memEn = 1'b0;
        tick;
        // reset the cycle after a host read grant
        host_req = 1'b1;
        host_addr = 32'h10;
        tick;
        host_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk1("t5_rvalid", host_rvalid, 1'b0);
        tick;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_rdata", host_rdata, 64'h0);
        chk1("t5_rvalid_after", host_rvalid, 1'b0);
        tick;
        // reset clears a partial starvation count
        cpu_memEn = 1'b1;
        cpu_memAddr = 32'h20;
        host_req = 1'b1;
        host_addr = 32'h11;
        repeat (3) tick;
        reset = 1'b1;
        @(negedge clk);
        chk1("t5_rst_stall", cpu_stall, 1'b0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("t5_gnt", host_gnt, i == 4);
            tick;
        end
        // host_req drop restarts the count
        repeat (3) tick;
        host_req = 1'b0;
        tick;
        host_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("t6_gnt", host_gnt, i == 4);
            tick;
        end
        cpu_memEn = 1'b0;
        host_req = 1'b0;
        repeat (3) tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
